// File: rtl/data_mem_responder.sv
// data_mem_responder: word memory answering a req/valid handshake LATENCY cycles
// after acceptance. Define DATA_MEM_RESP_ERR_EN to add the data_err port.
module data_mem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_req,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata
`ifdef DATA_MEM_RESP_ERR_EN
  ,
  output logic                       data_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic from_idle;
  logic acc_we;
  logic [BYTE_DATA_WIDTH-1:0] acc_be;
  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [AW-1:0] acc_idx;
  logic acc_oor;
  logic mem_acc;
  logic mem_we;
  logic unused_addr_bits;

  // With LATENCY=1 the access happens on the acceptance edge, so the
  // live inputs stand in for the not-yet-captured copies.
  always_comb begin
    from_idle = (state_q == IDLE);
    acc_we    = from_idle ? data_we : we_q;
    acc_be    = from_idle ? byte_enable : be_q;
    acc_addr  = from_idle ? data_addr : addr_q;
    acc_wdata = from_idle ? wdata : wdata_q;
    acc_idx   = acc_addr[AW+1:2];
    mem_acc   = (from_idle && data_req && DIRECT) ||
                ((state_q == BUSY) && (cnt_q <= CNT_ONE));
`ifdef DATA_MEM_RESP_ERR_EN
    acc_oor          = |acc_addr[DATA_WIDTH-1:AW+2];
    unused_addr_bits = ^acc_addr[1:0];
`else
    acc_oor          = 1'b0;
    unused_addr_bits = ^{acc_addr[DATA_WIDTH-1:AW+2], acc_addr[1:0]};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          we_d    = data_we;
          be_d    = byte_enable;
          addr_d  = data_addr;
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
          state_d = DIRECT ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = mem_acc;
    err_d   = mem_acc && acc_oor;
    mem_we  = mem_acc && acc_we && !acc_oor;
    rdata_d = rdata_q;
    if (mem_acc) begin
      rdata_d = (acc_we || acc_oor) ? '0 : mem[acc_idx];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_valid = valid_q;
  assign rdata      = rdata_q;
`ifdef DATA_MEM_RESP_ERR_EN
  assign data_err   = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
